mul16_seq_ctrl: RTL and testbench

- Sequencer that computes an unsigned 16x16 -> 32-bit product by time-multiplexing one external 8x8 -> 16-bit multiplier instance over four partial-product steps, accumulating the shifted partial products.
- Sits between a valid/ready operand source and result sink, and drives the shared 8x8 multiplier's operand inputs.

---
 rtl/mul16_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_mul16_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul16_seq_ctrl.sv
// Unsigned 16x16->32 multiply sequencer that reuses one external 8x8 multiplier
// over four partial-product steps and accumulates the shifted results.
module mul16_seq_ctrl #(
    parameter int MUL_LAT   = 0,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic        busy
);

    localparam int WCNT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MUL_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [15:0]         r_a;
    logic [15:0]         r_b;
    logic [31:0]         r_acc;
    logic [1:0]          r_step;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [31:0]         w_partial;
    logic                w_sample;
    logic                w_zeroOp;

    assign w_sample  = (r_wcnt == WCNT_MAX);
    assign w_zeroOp  = SKIP_ZERO && ((in_a == 16'h0000) || (in_b == 16'h0000));

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == MUL);
    assign out_p     = r_acc;

    // Operands are driven only in MUL so the shared multiplier stays quiet otherwise.
    always_comb begin
        w_stateNext = r_state;
        mul_a       = 8'h00;
        mul_b       = 8'h00;
        w_partial   = 32'h0000_0000;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_stateNext = w_zeroOp ? DONE : MUL;
                end
            end
            MUL: begin
                case (r_step)
                    2'd0: begin
                        mul_a     = r_a[7:0];
                        mul_b     = r_b[7:0];
                        w_partial = {16'h0000, mul_p};
                    end
                    2'd1: begin
                        mul_a     = r_a[7:0];
                        mul_b     = r_b[15:8];
                        w_partial = {8'h00, mul_p, 8'h00};
                    end
                    2'd2: begin
                        mul_a     = r_a[15:8];
                        mul_b     = r_b[7:0];
                        w_partial = {8'h00, mul_p, 8'h00};
                    end
                    default: begin
                        mul_a     = r_a[15:8];
                        mul_b     = r_b[15:8];
                        w_partial = {mul_p, 16'h0000};
                    end
                endcase
                if (w_sample && (r_step == 2'd3)) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_acc   <= 32'h0000_0000;
            r_step  <= 2'd0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_stateNext;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a    <= in_a;
                        r_b    <= in_b;
                        r_acc  <= 32'h0000_0000;
                        r_step <= 2'd0;
                        r_wcnt <= '0;
                    end
                end
                MUL: begin
                    // Step wraps 3->0 naturally as the last partial product lands.
                    if (w_sample) begin
                        r_acc  <= r_acc + w_partial;
                        r_wcnt <= '0;
                        r_step <= r_step + 2'd1;
                    end else begin
                        r_wcnt <= r_wcnt + WCNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Directed bench for mul16_seq_ctrl: three instances cover MUL_LAT=0 with and
// without zero bypass, and MUL_LAT=2 driven by a two-stage multiplier model.
module tb_mul16_seq_ctrl;

    logic              clk;
    logic              rst;
    logic [2:0]        inValid;
    logic [2:0]        inReady;
    logic [15:0]       inA;
    logic [15:0]       inB;
    logic [2:0][7:0]   mulA;
    logic [2:0][7:0]   mulB;
    logic [15:0]       mulP0;
    logic [15:0]       mulP1;
    logic [15:0]       mulP2;
    logic [15:0]       pipe1;
    logic [2:0]        outValid;
    logic              outReady;
    logic [2:0][31:0]  outP;
    logic [2:0]        busy;

    int checkCount = 0;
    int passCount  = 0;

    mul16_seq_ctrl #(.MUL_LAT(0), .SKIP_ZERO(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .in_a(inA), .in_b(inB), .mul_a(mulA[0]), .mul_b(mulB[0]), .mul_p(mulP0),
        .out_valid(outValid[0]), .out_ready(outReady), .out_p(outP[0]), .busy(busy[0])
    );

    mul16_seq_ctrl #(.MUL_LAT(0), .SKIP_ZERO(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .in_a(inA), .in_b(inB), .mul_a(mulA[1]), .mul_b(mulB[1]), .mul_p(mulP1),
        .out_valid(outValid[1]), .out_ready(outReady), .out_p(outP[1]), .busy(busy[1])
    );

    mul16_seq_ctrl #(.MUL_LAT(2), .SKIP_ZERO(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .in_a(inA), .in_b(inB), .mul_a(mulA[2]), .mul_b(mulB[2]), .mul_p(mulP2),
        .out_valid(outValid[2]), .out_ready(outReady), .out_p(outP[2]), .busy(busy[2])
    );

    assign mulP0 = {8'h00, mulA[0]} * {8'h00, mulB[0]};
    assign mulP1 = {8'h00, mulA[1]} * {8'h00, mulB[1]};

    // Product of the operands presented two edges earlier.
    always @(posedge clk) begin
        pipe1 <= {8'h00, mulA[2]} * {8'h00, mulB[2]};
        mulP2 <= pipe1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents one operand pair; returns #1 after the accept edge.
    task automatic applyStimulus(input int d, input logic [15:0] a, input logic [15:0] b);
        inA = a;
        inB = b;
        inValid[d] = 1'b1;
        @(posedge clk);
        #1;
        inValid[d] = 1'b0;
    endtask

    task automatic waitValid(input int d, input int maxCycles, output int cycles);
        cycles = 0;
        while (!outValid[d] && cycles < maxCycles) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic releaseResult(input int d);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput("backToIdle", {31'h0, inReady[d]}, 32'h1);
    endtask

    logic [7:0] expA0 [4] = '{8'h34, 8'h34, 8'h12, 8'h12};
    logic [7:0] expB0 [4] = '{8'h78, 8'h56, 8'h78, 8'h56};
    logic [7:0] expA2 [4] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
    logic [7:0] expB2 [4] = '{8'h00, 8'h01, 8'h00, 8'h01};

    logic [31:0] expQ [$];
    logic [31:0] expVal;
    int cycles;
    int accepted;
    int violations;
    int cyc;

    initial begin
        rst      = 1'b1;
        inValid  = 3'b000;
        outReady = 1'b0;
        inA      = 16'h0000;
        inB      = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstInReady",  {31'h0, inReady[0]},  32'h1);
        checkOutput("rstOutValid", {31'h0, outValid[0]}, 32'h0);
        checkOutput("rstOutP",     outP[0],              32'h0);
        checkOutput("rstBusy",     {31'h0, busy[0]},     32'h0);
        checkOutput("rstMulAB",    {16'h0, mulA[2], mulB[2]}, 32'h0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic product with per-step operand sequence.
        applyStimulus(0, 16'h1234, 16'h5678);
        for (int k = 0; k < 4; k++) begin
            checkOutput("seqMulA", {24'h0, mulA[0]}, {24'h0, expA0[k]});
            checkOutput("seqMulB", {24'h0, mulB[0]}, {24'h0, expB0[k]});
            checkOutput("seqBusy", {31'h0, busy[0]}, 32'h1);
            @(posedge clk);
            #1;
        end
        checkOutput("seqOutValid", {31'h0, outValid[0]}, 32'h1);
        checkOutput("seqBusyLow",  {31'h0, busy[0]},     32'h0);
        checkOutput("seqOutP",     outP[0],              32'h0626_0060);
        checkOutput("doneMulAB",   {16'h0, mulA[0], mulB[0]}, 32'h0);
        releaseResult(0);

        // All-ones operands and a stalled sink.
        applyStimulus(0, 16'hFFFF, 16'hFFFF);
        waitValid(0, 20, cycles);
        checkOutput("maxLatency", cycles, 32'd4);
        checkOutput("maxOutP", outP[0], 32'hFFFE_0001);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput("stallValid", {31'h0, outValid[0]}, 32'h1);
            checkOutput("stallOutP", outP[0], 32'hFFFE_0001);
        end
        releaseResult(0);

        // Zero operand: early exit with bypass, full run without.
        applyStimulus(0, 16'h0000, 16'hBEEF);
        checkOutput("skipValid", {31'h0, outValid[0]}, 32'h1);
        checkOutput("skipOutP", outP[0], 32'h0);
        checkOutput("skipMulAB", {16'h0, mulA[0], mulB[0]}, 32'h0);
        releaseResult(0);
        applyStimulus(1, 16'h0000, 16'hBEEF);
        checkOutput("noSkipBusy", {31'h0, busy[1]}, 32'h1);
        waitValid(1, 20, cycles);
        checkOutput("noSkipLatency", cycles, 32'd4);
        checkOutput("noSkipOutP", outP[1], 32'h0);
        releaseResult(1);

        // Multi-cycle multiplier: each operand pair held three cycles.
        applyStimulus(2, 16'h00FF, 16'h0100);
        for (int k = 0; k < 12; k++) begin
            checkOutput("latMulA", {24'h0, mulA[2]}, {24'h0, expA2[k / 3]});
            checkOutput("latMulB", {24'h0, mulB[2]}, {24'h0, expB2[k / 3]});
            @(posedge clk);
            #1;
        end
        checkOutput("latOutValid", {31'h0, outValid[2]}, 32'h1);
        checkOutput("latOutP", outP[2], 32'h0000_FF00);
        releaseResult(2);

        // Asynchronous reset while step 2 is in flight.
        applyStimulus(0, 16'hABCD, 16'h1234);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("preRstMulA", {24'h0, mulA[0]}, 32'h0000_00AB);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncInReady",  {31'h0, inReady[0]},  32'h1);
        checkOutput("asyncOutValid", {31'h0, outValid[0]}, 32'h0);
        checkOutput("asyncOutP",     outP[0],              32'h0);
        checkOutput("asyncMulAB",    {16'h0, mulA[0], mulB[0]}, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("postRstValid", {31'h0, outValid[0]}, 32'h0);
        applyStimulus(0, 16'h0002, 16'h0003);
        waitValid(0, 20, cycles);
        checkOutput("postRstLatency", cycles, 32'd4);
        checkOutput("postRstOutP", outP[0], 32'h0000_0006);
        releaseResult(0);

        // Continuous random traffic with an always-ready sink.
        accepted   = 0;
        violations = 0;
        cyc        = 0;
        outReady   = 1'b1;
        inA        = 16'($urandom);
        inB        = 16'($urandom);
        inValid[0] = 1'b1;
        while (cyc < 20000 && (accepted < 1000 || expQ.size() > 0)) begin
            if (inReady[0] && (busy[0] || outValid[0])) violations++;
            if (outValid[0]) begin
                if (expQ.size() == 0) begin
                    violations++;
                end else begin
                    expVal = expQ.pop_front();
                    checkOutput("randProduct", outP[0], expVal);
                end
            end
            if (inReady[0] && inValid[0]) begin
                expQ.push_back({16'h0000, inA} * {16'h0000, inB});
                accepted++;
            end
            @(posedge clk);
            #1;
            cyc++;
            inA = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
            inB = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
            if (accepted >= 1000) inValid[0] = 1'b0;
        end
        outReady = 1'b0;
        checkOutput("randAccepted", accepted, 32'd1000);
        checkOutput("randDrained", expQ.size(), 32'd0);
        checkOutput("randReadyExcl", violations, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
